// File: rtl/ov7670_config_sequencer_if.sv
// ROM read port and SCCB write-command channel between the config sequencer
// and its ROM / SCCB master.
interface ov7670_config_sequencer_if;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        sccb_valid;
  logic        sccb_ready;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_data;
  logic        sccb_done;

  modport master (
    output rom_addr,
    input  rom_dout,
    output sccb_valid,
    input  sccb_ready,
    output sccb_reg,
    output sccb_data,
    input  sccb_done
  );

  modport slave (
    input  rom_addr,
    output rom_dout,
    input  sccb_valid,
    output sccb_ready,
    input  sccb_reg,
    input  sccb_data,
    output sccb_done
  );
endinterface

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 configuration ROM and issues each entry as an SCCB write,
// honouring delay (16'hFFF0) and end (16'hFFFF) markers.
module ov7670_config_sequencer #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned DELAY_MS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  ov7670_config_sequencer_if.master bus,
  output logic busy,
  output logic done
);

  localparam int unsigned DELAY_CYCLES = (CLK_FREQ / 1000) * DELAY_MS;
  localparam int unsigned CNT_W        = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [15:0] END_MARK     = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK   = 16'hFFF0;
  localparam logic [7:0]  LAST_ADDR    = 8'hFF;

  if (DELAY_CYCLES < 1) begin : g_bad_delay
    $error("DELAY_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT_DONE,
    S_DELAY,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [7:0]         reg_q, reg_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               advance;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= 8'd0;
      valid_q <= 1'b0;
      reg_q   <= 8'd0;
      data_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    advance = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d  = 8'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (bus.rom_dout == END_MARK) begin
          state_d = S_DONE;
        end else if (bus.rom_dout == DELAY_MARK) begin
          cnt_d   = CNT_W'(DELAY_CYCLES - 1);
          state_d = S_DELAY;
        end else begin
          reg_d   = bus.rom_dout[15:8];
          data_d  = bus.rom_dout[7:0];
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.sccb_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: advance = bus.sccb_done;
      S_DELAY: begin
        if (cnt_q == '0) advance = 1'b1;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Address saturates at the last ROM entry so the walk always terminates
    if (advance) begin
      if (addr_q == LAST_ADDR) begin
        state_d = S_DONE;
      end else begin
        addr_d  = 8'(addr_q + 8'd1);
        state_d = S_FETCH;
      end
    end

    valid_d = (state_d == S_SEND);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  assign bus.rom_addr   = addr_q;
  assign bus.sccb_valid = valid_q;
  assign bus.sccb_reg   = reg_q;
  assign bus.sccb_data  = data_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Directed bench for ov7670_config_sequencer with a 1-cycle ROM model and an
// SCCB master model that pulses done 5 cycles after each handshake.
module tb_ov7670_config_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  ov7670_config_sequencer_if bus ();

  ov7670_config_sequencer #(
    .CLK_FREQ(1000),
    .DELAY_MS(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ROM model
  logic [15:0] rom [256];
  always @(posedge clk) bus.rom_dout <= rom[bus.rom_addr];

  // SCCB master model
  int unsigned tmr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr           <= 0;
      bus.sccb_done <= 1'b0;
    end else begin
      bus.sccb_done <= (tmr == 1);
      if (bus.sccb_valid && bus.sccb_ready) tmr <= 5;
      else if (tmr != 0)                    tmr <= tmr - 1;
    end
  end

  // Bus monitor: command log, stability and spacing checks, address timing
  logic [15:0] cmdq [$];
  int cyc = 0;
  int stab_err = 0, spacing_err = 0, valid_at1 = 0;
  int addr_first [256];
  logic hold_prev = 1'b0, prev_valid = 1'b0, outstanding = 1'b0;
  logic [7:0] prev_reg, prev_data;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      hold_prev   = 1'b0;
      prev_valid  = 1'b0;
      outstanding = 1'b0;
    end else begin
      if (hold_prev && !(bus.sccb_valid && bus.sccb_reg == prev_reg && bus.sccb_data == prev_data))
        stab_err++;
      if (bus.sccb_valid && !prev_valid && outstanding) spacing_err++;
      if (bus.sccb_done) outstanding = 1'b0;
      if (bus.sccb_valid && bus.sccb_ready) begin
        cmdq.push_back({bus.sccb_reg, bus.sccb_data});
        outstanding = 1'b1;
      end
      hold_prev  = bus.sccb_valid && !bus.sccb_ready;
      prev_valid = bus.sccb_valid;
      prev_reg   = bus.sccb_reg;
      prev_data  = bus.sccb_data;
      if (addr_first[bus.rom_addr] < 0) addr_first[bus.rom_addr] = cyc;
      if (bus.sccb_valid && bus.rom_addr == 8'd1) valid_at1++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    cmdq.delete();
    for (int i = 0; i < 256; i++) addr_first[i] = -1;
    valid_at1 = 0;
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    for (int i = 0; i < max && !done; i++) @(negedge clk);
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !bus.sccb_valid; i++) @(negedge clk);
    check(tag, 32'(bus.sccb_valid), 32'd1);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280;
    rom[1] = 16'h1101;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"},  32'(bus.rom_addr),   32'd0);
    check({tag, "_valid"}, 32'(bus.sccb_valid), 32'd0);
    check({tag, "_reg"},   32'(bus.sccb_reg),   32'd0);
    check({tag, "_data"},  32'(bus.sccb_data),  32'd0);
    check({tag, "_busy"},  32'(busy),           32'd0);
    check({tag, "_done"},  32'(done),           32'd0);
  endtask

  initial begin
    bus.sccb_ready = 1'b1;
    load_basic();

    // 1: basic sequence and start latency
    do_reset();
    check_idle_outputs("rst");
    pulse_start();
    check("t1_busy_fetch", 32'(busy), 32'd1);
    check("t1_valid_fetch", 32'(bus.sccb_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_decode", 32'(bus.sccb_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_k2", 32'(bus.sccb_valid), 32'd1);
    check("t1_reg_k2", 32'(bus.sccb_reg), 32'h12);
    wait_done(200, "t1_done");
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_addr_end", 32'(bus.rom_addr), 32'd2);
    check("t1_ncmd", 32'(cmdq.size()), 32'd2);
    if (cmdq.size() == 2) begin
      check("t1_cmd0", 32'(cmdq[0]), 32'h1280);
      check("t1_cmd1", 32'(cmdq[1]), 32'h1101);
    end

    // 2: backpressure on the first command
    do_reset();
    bus.sccb_ready = 1'b0;
    pulse_start();
    wait_valid("t2_valid_up");
    begin
      logic stable;
      stable = 1'b1;
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        stable &= bus.sccb_valid && bus.sccb_reg == 8'h12 && bus.sccb_data == 8'h80;
      end
      check("t2_stable", 32'(stable), 32'd1);
    end
    check("t2_no_cmd_yet", 32'(cmdq.size()), 32'd0);
    bus.sccb_ready = 1'b1;
    @(negedge clk);
    check("t2_valid_after_hs", 32'(bus.sccb_valid), 32'd0);
    check("t2_one_hs", 32'(cmdq.size()), 32'd1);
    wait_done(200, "t2_done");
    check("t2_ncmd", 32'(cmdq.size()), 32'd2);
    check("t2_stab_err", 32'(stab_err), 32'd0);

    // 3: delay marker
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1101;
    do_reset();
    pulse_start();
    wait_done(300, "t3_done");
    check("t3_fetch_gap", 32'(addr_first[2] - addr_first[1]), 32'd12);
    check("t3_valid_in_delay", 32'(valid_at1), 32'd0);
    check("t3_ncmd", 32'(cmdq.size()), 32'd2);
    if (cmdq.size() == 2) check("t3_cmd1", 32'(cmdq[1]), 32'h1101);
    check("t3_addr_end", 32'(bus.rom_addr), 32'd3);

    // 4: no end marker, address saturates at 255
    for (int i = 0; i < 256; i++) rom[i] = 16'h0102;
    do_reset();
    pulse_start();
    wait_done(4000, "t4_done");
    repeat (20) @(negedge clk);
    check("t4_ncmd", 32'(cmdq.size()), 32'd256);
    check("t4_addr_end", 32'(bus.rom_addr), 32'd255);
    check("t4_done_held", 32'(done), 32'd1);
    check("t4_last_cmd", 32'(cmdq[$]), 32'h0102);

    // 5a: reset during SEND
    load_basic();
    do_reset();
    bus.sccb_ready = 1'b0;
    pulse_start();
    wait_valid("t5_valid_up");
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("t5_send_rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.sccb_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_valid", 32'(bus.sccb_valid), 32'd0);
    check("t5_idle_ncmd", 32'(cmdq.size()), 32'd0);

    // 5b: reset during DELAY
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1101;
    do_reset();
    pulse_start();
    for (int i = 0; i < 50 && bus.rom_addr != 8'd1; i++) @(negedge clk);
    check("t5_reach_delay_entry", 32'(bus.rom_addr), 32'd1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("t5_delay_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("t5_idle2_busy", 32'(busy), 32'd0);
    check("t5_idle2_addr", 32'(bus.rom_addr), 32'd0);

    // 6: start ignored while busy, replay from DONE
    load_basic();
    do_reset();
    pulse_start();
    wait_valid("t6_valid_up");
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done(200, "t6_done1");
    check("t6_ncmd1", 32'(cmdq.size()), 32'd2);
    check("t6_addr1", 32'(bus.rom_addr), 32'd2);
    cmdq.delete();
    pulse_start();
    check("t6_done_clr", 32'(done), 32'd0);
    check("t6_busy_restart", 32'(busy), 32'd1);
    check("t6_addr_restart", 32'(bus.rom_addr), 32'd0);
    wait_done(200, "t6_done2");
    check("t6_ncmd2", 32'(cmdq.size()), 32'd2);
    if (cmdq.size() == 2) begin
      check("t6_cmd0", 32'(cmdq[0]), 32'h1280);
      check("t6_cmd1", 32'(cmdq[1]), 32'h1101);
    end

    check("spacing_err", 32'(spacing_err), 32'd0);
    check("stab_err_total", 32'(stab_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
